// File: rtl/demux_pkg.sv
// Shared widths, types and control states for the 1-to-4 serial deserializer.
package demux_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned WORD_W = 4;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [WORD_W-1:0] word_t;

    // Slot index whose acceptance completes a word.
    localparam sel_t SEL_LAST = sel_t'(WORD_W - 1);

    // FILL: no word pending; HOLD: out carries an unconsumed word.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/demux_slot_dec.sv
// Combinational 2-to-4 one-hot decoder: maps the fill slot to the word bit it writes.
module demux_slot_dec
    import demux_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  sel_t  i_sel,
    output word_t o_we
);

    word_t w_onehot;

    assign w_onehot = word_t'(1) << i_sel;

    // Slot 0 lands on the top bit when MSB_FIRST, else on bit 0.
    always_comb begin
        o_we = '0;
        for (int k = 0; k < WORD_W; k++) begin
            o_we[k] = MSB_FIRST ? w_onehot[WORD_W-1-k] : w_onehot[k];
        end
    end

endmodule

// File: rtl/demux1x4_deser.sv
// Serial-to-4-bit deserializer with valid/ready on both sides.
// Optional feature: define DEMUX_PARITY_EN to add out_par (XOR of out).
module demux1x4_deser
    import demux_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in,
    input  logic  in_valid,
    output logic  in_ready,
    output sel_t  s,
    output word_t out,
    output logic  out_valid,
`ifdef DEMUX_PARITY_EN
    output logic  out_par,
`endif
    input  logic  out_ready
);

    ctrl_state_t r_state;
    sel_t        r_sel;
    word_t       r_asm;
    word_t       r_out;
`ifdef DEMUX_PARITY_EN
    logic        r_par;
`endif

    word_t w_we;
    word_t w_word;
    logic  w_accept;
    logic  w_last;

    demux_slot_dec #(
        .MSB_FIRST (MSB_FIRST)
    ) u_slot_dec (
        .i_sel (r_sel),
        .o_we  (w_we)
    );

    // Only the final slot must wait for the pending word to drain.
    assign in_ready  = !((r_sel == SEL_LAST) && (r_state == HOLD) && !out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_sel == SEL_LAST);
    assign w_word    = (r_asm & ~w_we) | (w_we & {WORD_W{in}});

    assign s         = r_sel;
    assign out       = r_out;
    assign out_valid = (r_state == HOLD);
`ifdef DEMUX_PARITY_EN
    assign out_par   = r_par;
`endif

    // Assembly, slot counter and FILL/HOLD control with registered word output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_sel   <= '0;
            r_asm   <= '0;
            r_out   <= '0;
`ifdef DEMUX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_asm <= w_word;
                r_sel <= sel_t'(r_sel + sel_t'(1));
            end
            if (w_accept && w_last) begin
                r_out   <= w_word;
`ifdef DEMUX_PARITY_EN
                r_par   <= ^w_word;
`endif
                r_state <= HOLD;
            end else if ((r_state == HOLD) && out_ready) begin
                r_state <= FILL;
            end
        end
    end

endmodule

// File: tb/tb_demux1x4_deser.sv
// Directed self-checking bench for demux1x4_deser (MSB_FIRST=1 and MSB_FIRST=0 side by side).
module tb_demux1x4_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       in;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready,  in_ready_l;
    logic [1:0] s,         s_l;
    logic [3:0] out,       out_l;
    logic       out_valid, out_valid_l;
`ifdef DEMUX_PARITY_EN
    logic       out_par,   out_par_l;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux1x4_deser #(.MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .out       (out),
        .out_valid (out_valid),
`ifdef DEMUX_PARITY_EN
        .out_par   (out_par),
`endif
        .out_ready (out_ready)
    );

    demux1x4_deser #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .s         (s_l),
        .out       (out_l),
        .out_valid (out_valid_l),
`ifdef DEMUX_PARITY_EN
        .out_par   (out_par_l),
`endif
        .out_ready (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        in       = b;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_s",         4'(s),         4'd0);
        chk("rst_out",       out,           4'b0000);
        chk("rst_out_valid", 4'(out_valid), 4'd0);
        chk("rst_in_ready",  4'(in_ready),  4'd1);

        // Stream 0,0,1,1 with out_ready=1; s walks 0,1,2,3,0
        chk("s_seq0", 4'(s), 4'd0);
        send(1'b0);
        chk("s_seq1", 4'(s), 4'd1);
        send(1'b0);
        chk("s_seq2", 4'(s), 4'd2);
        send(1'b1);
        chk("s_seq3", 4'(s), 4'd3);
        chk("ov_before_4th", 4'(out_valid), 4'd0);
        send(1'b1);
        chk("s_seq4", 4'(s), 4'd0);
        chk("ov_after_4th", 4'(out_valid), 4'd1);
        chk("word_msb_0011", out, 4'b0011);
        chk("word_lsb_1100", out_l, 4'b1100);

        // Idle cycle: word consumed, nothing accepted
        in_valid = 1'b0;
        tick();
        chk("consume_ov", 4'(out_valid), 4'd0);
        chk("idle_s",     4'(s),         4'd0);
        chk("idle_out",   out,           4'b0011);

        // Backpressure: 1,0,1,0 held, then 1,1,1 fill slots 0..2
        out_ready = 1'b0;
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        chk("bp_ov",   4'(out_valid), 4'd1);
        chk("bp_word", out,           4'b1010);
        send(1'b1); send(1'b1); send(1'b1);
        chk("bp_hold_out", out,          4'b1010);
        chk("bp_s3",       4'(s),        4'd3);
        chk("bp_in_ready", 4'(in_ready), 4'd0);
        // Stalled bit 0 must not be taken while in_ready=0
        in = 1'b0; in_valid = 1'b1;
        tick();
        chk("stall_s",   4'(s), 4'd3);
        chk("stall_out", out,   4'b1010);
        // Consume and complete in the same cycle
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 4'(in_ready), 4'd1);
        tick();
        chk("swap_ov",       4'(out_valid), 4'd1);
        chk("swap_word",     out,           4'b1110);
        chk("swap_word_lsb", out_l,         4'b0111);
        chk("swap_s",        4'(s),         4'd0);
        in_valid = 1'b0;
        tick();
        chk("drain_ov", 4'(out_valid), 4'd0);

        // Reset after two accepted bits discards the partial word
        send(1'b1); send(1'b1);
        chk("partial_s", 4'(s), 4'd2);
        rst = 1'b1; in = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_s",   4'(s),         4'd0);
        chk("midrst_ov",  4'(out_valid), 4'd0);
        chk("midrst_out", out,           4'b0000);
        out_ready = 1'b0;
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        chk("after_rst_word", out,           4'b1111);
        chk("after_rst_ov",   4'(out_valid), 4'd1);
        // Reset drops a pending word
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("drop_ov",  4'(out_valid), 4'd0);
        chk("drop_out", out,           4'b0000);
        out_ready = 1'b1;

`ifdef DEMUX_PARITY_EN
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("par_word_1011", out,         4'b1011);
        chk("par_1011",      4'(out_par), 4'd1);
        send(1'b0); send(1'b0); send(1'b1); send(1'b1);
        chk("par_word_0011", out,         4'b0011);
        chk("par_0011",      4'(out_par), 4'd0);
        in_valid = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1x4_deser.md
DEMUX1X4_DESER -- requirements
Module: demux1x4_deser

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1: 1 places slot 0 at out[3] and slot 3 at out[0]; 0 places slot 0 at out[0].
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in  input  1  serial data bit.
REQ-005 The block SHALL have port in_valid  input  1  in holds a valid bit this cycle.
REQ-006 The block SHALL have port in_ready  output  1  block accepts in this cycle.
REQ-007 The block SHALL have port s  output  2  slot index the next accepted bit fills (0..3).
REQ-008 The block SHALL have port out  output  4  assembled word.
REQ-009 The block SHALL have port out_valid  output  1  out holds an unconsumed word.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes out this cycle.

Function
REQ-011 A bit SHALL be accepted when in_valid && in_ready at a rising clk edge.
REQ-012 An accepted bit SHALL be written to the assembly register at the position selected by s and MSB_FIRST; s SHALL then increment by 1, wrapping 3 -> 0.
REQ-013 Acceptance at s=3 SHALL copy the completed word into out and set out_valid on the next cycle, giving one-cycle latency from the 4th accept to out_valid.
REQ-014 A word SHALL be consumed when out_valid && out_ready; out_valid SHALL then clear unless a new word completes in the same cycle, in which case out SHALL take the new word and out_valid SHALL stay 1.
REQ-015 in_ready SHALL be a combinational function of state and out_ready: 0 only when s=3 && out_valid && !out_ready, else 1. Slots 0..2 SHALL fill while a word is pending.
REQ-016 out SHALL be stable while out_valid && !out_ready.
REQ-017 Bits not accepted (in_valid=0, or in_ready=0) SHALL leave s, the assembly register and out unchanged.
REQ-018 The control states SHALL be FILL (out_valid=0) and HOLD (out_valid=1). FILL->HOLD on accept at s=3. HOLD->FILL on consume without completion. HOLD->HOLD on completion with consume, or on no consume.

Reset
REQ-019 While rst=1 at a clk edge, the block SHALL clear s, the assembly register, out (4'b0000) and out_valid. in_ready SHALL read 1 the cycle after reset.
REQ-020 rst asserted mid-word SHALL discard the partial word; a pending out SHALL be dropped; rst SHALL take priority over any handshake in the same cycle.

Configuration
REQ-021 With DEMUX_PARITY_EN defined, the block SHALL add output out_par (1 bit) equal to the XOR of out, registered with out and cleared by reset.
REQ-022 Without DEMUX_PARITY_EN, out_par and its logic SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-023 Package demux_pkg SHALL hold SEL_W=2, WORD_W=4, typedef sel_t (SEL_W bits) and typedef word_t (WORD_W bits).
REQ-024 Sub-module demux_slot_dec SHALL implement the combinational 2-to-4 one-hot slot decoder (s, MSB_FIRST -> write enable); all state SHALL remain in demux1x4_deser.

Verification
REQ-025 Scenario: reset, then bits 0,0,1,1 with in_valid=1 and out_ready=1 -> out=4'b0011 and out_valid=1 exactly one cycle after the 4th accept; s sequence 0,1,2,3,0.
REQ-026 Scenario: MSB_FIRST=0 with the same stream -> out=4'b1100.
REQ-027 Scenario: out_ready=0, 7 bits 1,0,1,0,1,1,1 -> first word 4'b1010 held; in_ready=0 with s=3 while that word is unconsumed; raising out_ready -> word 4'b1110 loads the next cycle with no bit lost.
REQ-028 Scenario: a word completes in the same cycle the previous word is consumed -> out_valid stays 1 and out updates.
REQ-029 Scenario: rst pulse after 2 accepted bits -> s=0 and out_valid=0; the next 4 bits 1,1,1,1 give out=4'b1111.
REQ-030 Scenario: with DEMUX_PARITY_EN, word 4'b1011 -> out_par=1; word 4'b0011 -> out_par=0.
